if_id_fetch_queue: RTL and testbench

- Decoupling buffer between the instruction-fetch stage and the decode stage; replaces the plain IF/ID pipeline register.
- Captures {pc, instruction} pairs from fetch into a small circular queue and presents the oldest entry to decode.
- Uses valid/ready handshakes on both sides; in_ready drives the fetch stage's freeze (freeze = ~in_ready).
- Branch-taken flush discards all buffered (wrong-path) entries.

---
 rtl/if_id_fetch_queue_pkg.sv | 11 +
 rtl/if_id_fetch_queue_ptr_ctrl.sv | 47 ++++
 rtl/if_id_fetch_queue.sv | 52 +++++
 tb/tb_if_id_fetch_queue.sv | 136 +++++++++++++
 4 files changed

// File: rtl/if_id_fetch_queue_pkg.sv
// Shared ISA constants and the queue entry layout used by the IF/ID fetch queue.
package if_id_fetch_queue_pkg;
  localparam int LEN_ADDRESS     = 32;
  localparam int LEN_INSTRUCTION = 32;
  localparam logic [LEN_INSTRUCTION-1:0] NOP_INSTRUCTION = 32'h0000_0000;

  typedef struct packed {
    logic [LEN_ADDRESS-1:0]     pc;
    logic [LEN_INSTRUCTION-1:0] instruction;
  } fetch_entry_t;
endpackage

// File: rtl/if_id_fetch_queue_ptr_ctrl.sv
// Pointer, occupancy and handshake control for the IF/ID fetch queue.
module queue_ptr_ctrl #(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             in_ready,
  output logic             out_valid
);
  // Both flags come from registered count only, so a full queue refuses a push
  // even when decode pops in the same cycle.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: buffers {pc, instruction} from fetch and presents the oldest to decode.
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [LEN_ADDRESS-1:0]     pc_in,
  input  logic [LEN_INSTRUCTION-1:0] instruction_in,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [LEN_ADDRESS-1:0]     pc_out,
  output logic [LEN_INSTRUCTION-1:0] instruction_out,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           count
);
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  fetch_entry_t     entry_mem [DEPTH];
  fetch_entry_t     head;

  queue_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .push      (push),
    .pop       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );

  // Storage is never reset; out_valid alone decides what decode sees.
  always_ff @(posedge clk) begin
    if (push) entry_mem[wr_ptr] <= '{pc: pc_in, instruction: instruction_in};
  end

  assign head            = entry_mem[rd_ptr];
  assign pc_out          = out_valid ? head.pc : '0;
  assign instruction_out = out_valid ? head.instruction : NOP_INSTRUCTION;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed vector table, streaming sequence, random vs queue model.
module tb_if_id_fetch_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] pc_in, instruction_in;
  logic        in_ready, out_valid;
  logic [31:0] pc_out, instruction_out;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .out_ready       (out_ready),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] pc, ins;
    logic        ordy;
    logic        ov, ir;
    logic [1:0]  cnt;
    logic [31:0] epc, eins;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
    rst = r; flush = f; in_valid = iv; pc_in = pc; instruction_in = ins; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir, input logic [1:0] cnt,
                         input logic [31:0] epc, input logic [31:0] eins);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".pc_out"}, pc_out, epc);
    chk({tag, ".instr_out"}, instruction_out, eins);
  endtask

  logic [63:0] model[$];
  logic        m_push, m_pop;
  logic [63:0] m_head;

  initial begin
    // {rst, flush, iv, pc, ins, out_ready} -> state visible after the edge
    vecs.push_back('{1,0,0, 32'd0,   32'h0,        0, 0,1,2'd0, 32'd0,   32'h0});
    vecs.push_back('{1,0,0, 32'd0,   32'h0,        0, 0,1,2'd0, 32'd0,   32'h0});
    vecs.push_back('{0,0,1, 32'd4,   32'hE3A01005, 1, 1,1,2'd1, 32'd4,   32'hE3A01005});
    vecs.push_back('{0,0,0, 32'd0,   32'h0,        1, 0,1,2'd0, 32'd0,   32'h0});
    vecs.push_back('{0,0,1, 32'd4,   32'h11,       0, 1,1,2'd1, 32'd4,   32'h11});
    vecs.push_back('{0,0,1, 32'd8,   32'h22,       0, 1,0,2'd2, 32'd4,   32'h11});
    vecs.push_back('{0,0,1, 32'd12,  32'h33,       0, 1,0,2'd2, 32'd4,   32'h11});
    vecs.push_back('{0,0,1, 32'd12,  32'h33,       1, 1,1,2'd1, 32'd8,   32'h22});
    vecs.push_back('{0,0,1, 32'd12,  32'h33,       1, 1,1,2'd1, 32'd12,  32'h33});
    vecs.push_back('{0,0,0, 32'd0,   32'h0,        1, 0,1,2'd0, 32'd0,   32'h0});
    vecs.push_back('{0,0,1, 32'd4,   32'h44,       0, 1,1,2'd1, 32'd4,   32'h44});
    vecs.push_back('{0,0,1, 32'd8,   32'h88,       0, 1,0,2'd2, 32'd4,   32'h44});
    vecs.push_back('{0,1,1, 32'd12,  32'hCC,       0, 0,1,2'd0, 32'd0,   32'h0});
    vecs.push_back('{0,0,0, 32'd0,   32'h0,        1, 0,1,2'd0, 32'd0,   32'h0});
    vecs.push_back('{0,0,1, 32'd4,   32'h44,       0, 1,1,2'd1, 32'd4,   32'h44});
    vecs.push_back('{0,0,1, 32'd8,   32'h88,       0, 1,0,2'd2, 32'd4,   32'h44});
    vecs.push_back('{1,1,1, 32'd12,  32'hCC,       0, 0,1,2'd0, 32'd0,   32'h0});
    vecs.push_back('{0,0,1, 32'd100, 32'h64,       0, 1,1,2'd1, 32'd100, 32'h64});
    vecs.push_back('{0,0,0, 32'd0,   32'h0,        1, 0,1,2'd0, 32'd0,   32'h0});

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].cnt, vecs[i].epc, vecs[i].eins);
    end

    // Streaming: one push and one pop per cycle, pointers wrap five times.
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, 32'(4 * (k + 1)), 32'(32'hA000 + k), 1);
      step();
      chk_all($sformatf("stream%0d", k), 1'b1, 1'b1, 2'd1, 32'(4 * (k + 1)), 32'(32'hA000 + k));
    end
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk_all("stream_drain", 1'b0, 1'b1, 2'd0, 32'd0, 32'h0);

    // Random traffic against a plain FIFO model.
    model.delete();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, 1'($urandom),
            $urandom, $urandom, 1'($urandom));
      m_push = in_valid && (model.size() < DEPTH) && !flush;
      m_pop  = out_ready && (model.size() > 0) && !flush;
      if (rst || flush) begin
        model.delete();
      end else begin
        if (m_pop) void'(model.pop_front());
        if (m_push) model.push_back({pc_in, instruction_in});
      end
      step();
      if (model.size() > 0) m_head = model[0];
      else                  m_head = '0;
      chk_all($sformatf("rand%0d", n), model.size() > 0, model.size() < DEPTH,
              2'(model.size()), m_head[63:32], m_head[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
